compare_iter: RTL and testbench

//   Parametrised, multi-cycle magnitude comparator for the MIPS datapath (slt/sltu, branch compares).

---
 rtl/compare_pkg.sv | 20 ++
 rtl/compare_slice.sv | 16 +
 rtl/compare_iter.sv | 126 ++++++++++++
 tb/tb_compare_iter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// Shared definitions for the iterative magnitude comparator: FSM encoding
// and slice-count helpers used to size the slice index register.
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice compare still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/compare_slice.sv
// Combinational CHUNK-bit unsigned compare of one operand slice.
module compare_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             big_o,
    output logic             equ_o,
    output logic             les_o
);

    assign big_o = (a_i > b_i);
    assign equ_o = (a_i == b_i);
    assign les_o = (a_i < b_i);

endmodule

// File: rtl/compare_iter.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle, with
// valid/ready handshakes on input and output and optional early exit.
module compare_iter
    import compare_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             bigger,
    output logic             equal,
    output logic             less,
    output logic             busy
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  a_d, b_d;
    logic [IDXW-1:0]   idx_q;
    logic              rec_diff_q, rec_big_q;
    logic              bigger_q, equal_q, less_q;

    logic [CHUNK-1:0]  slice_a, slice_b;
    logic              s_big, s_equ, s_les;
    logic              slice_diff, any_diff, big_now, les_now, finish;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        a_d = a;
        b_d = b;
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        if (is_signed) begin
            a_d[WIDTH-1] = ~a[WIDTH-1];
            b_d[WIDTH-1] = ~b[WIDTH-1];
        end
    end

    assign slice_a = a_q[idx_q*CHUNK +: CHUNK];
    assign slice_b = b_q[idx_q*CHUNK +: CHUNK];

    compare_slice #(.CHUNK(CHUNK)) u_slice (
        .a_i   (slice_a),
        .b_i   (slice_b),
        .big_o (s_big),
        .equ_o (s_equ),
        .les_o (s_les)
    );

    // The first recorded difference always wins over the current slice.
    assign slice_diff = ~s_equ;
    assign any_diff   = rec_diff_q | slice_diff;
    assign big_now    = rec_diff_q ? rec_big_q  : s_big;
    assign les_now    = rec_diff_q ? ~rec_big_q : s_les;
    assign finish     = ((EARLY_EXIT != 0) && slice_diff) || (idx_q == '0);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand registers are plain flops, not a memory, so
        // clearing them on reset costs nothing and keeps the datapath defined.
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            rec_diff_q <= 1'b0;
            rec_big_q  <= 1'b0;
            bigger_q   <= 1'b0;
            equal_q    <= 1'b0;
            less_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_d;
                        b_q        <= b_d;
                        idx_q      <= IDX_TOP;
                        rec_diff_q <= 1'b0;
                        rec_big_q  <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (slice_diff && !rec_diff_q) begin
                        rec_diff_q <= 1'b1;
                        rec_big_q  <= s_big;
                    end
                    if (finish) begin
                        bigger_q <= big_now;
                        equal_q  <= ~any_diff;
                        less_q   <= les_now;
                        state_q  <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign bigger    = bigger_q;
    assign equal     = equal_q;
    assign less      = less_q;

endmodule

// File: tb/tb_compare_iter.sv
// Directed bench for compare_iter across four configurations, checked
// against an arithmetic reference model of flags and latency.
module tb_compare_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid_s  = '0;
    logic [3:0]  is_signed_s = '0;
    logic [3:0]  out_ready_s = '0;
    logic [63:0] a_s [4];
    logic [63:0] b_s [4];
    logic [3:0]  in_ready_s, out_valid_s, bigger_s, equal_s, less_s, busy_s;
    logic [2:0]  exp_flags [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // u0: default; u1: fixed latency; u2: 64/16; u3: single full-width slice
    compare_iter #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0][31:0]), .b(b_s[0][31:0]), .is_signed(is_signed_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .bigger(bigger_s[0]), .equal(equal_s[0]), .less(less_s[0]), .busy(busy_s[0]));

    compare_iter #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1][31:0]), .b(b_s[1][31:0]), .is_signed(is_signed_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .bigger(bigger_s[1]), .equal(equal_s[1]), .less(less_s[1]), .busy(busy_s[1]));

    compare_iter #(.WIDTH(64), .CHUNK(16), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .a(a_s[2]), .b(b_s[2]), .is_signed(is_signed_s[2]),
        .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
        .bigger(bigger_s[2]), .equal(equal_s[2]), .less(less_s[2]), .busy(busy_s[2]));

    compare_iter #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[3]), .in_ready(in_ready_s[3]),
        .a(a_s[3][31:0]), .b(b_s[3][31:0]), .is_signed(is_signed_s[3]),
        .out_valid(out_valid_s[3]), .out_ready(out_ready_s[3]),
        .bigger(bigger_s[3]), .equal(equal_s[3]), .less(less_s[3]), .busy(busy_s[3]));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference: flags from signed/unsigned arithmetic, latency from the
    // highest differing bit of the raw operands.
    function automatic void model(input int i, input logic [63:0] a, input logic [63:0] b,
                                  input logic sgn, output logic [2:0] fl, output int k);
        int w, c, ee, n, hi;
        logic [63:0] mask, x, y, d;
        logic gt, eq;
        case (i)
            0:       begin w = 32; c = 8;  ee = 1; end
            1:       begin w = 32; c = 8;  ee = 0; end
            2:       begin w = 64; c = 16; ee = 1; end
            default: begin w = 32; c = 32; ee = 1; end
        endcase
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = a & mask;
        y = b & mask;
        if (sgn && x[w-1]) x = x | ~mask;
        if (sgn && y[w-1]) y = y | ~mask;
        gt = sgn ? ($signed(x) > $signed(y)) : (x > y);
        eq = (x == y);
        fl = {gt, eq, ~gt & ~eq};
        n = w / c;
        d = x ^ y;
        if (d == '0 || ee == 0) begin
            k = n;
        end else begin
            hi = 0;
            for (int j = 0; j < w; j++) if (d[j]) hi = j;
            k = n - hi / c;
        end
    endfunction

    // Flags must match the model on every cycle a result is presented.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_n && out_valid_s[i])
                check($sformatf("u%0d flags", i), {bigger_s[i], equal_s[i], less_s[i]}, exp_flags[i]);
        end
    end

    task automatic run_op(input int i, input logic [63:0] a, input logic [63:0] b, input logic sgn,
                          input logic [2:0] lit_fl, input int lit_k, input int hold, input string nm);
        logic [2:0] mfl;
        int mk, k;
        model(i, a, b, sgn, mfl, mk);
        check({nm, " model flags"}, mfl, lit_fl);
        check({nm, " model k"}, mk, lit_k);
        @(negedge clk);
        check({nm, " in_ready idle"}, in_ready_s[i], 1'b1);
        a_s[i] = a; b_s[i] = b; is_signed_s[i] = sgn;
        exp_flags[i] = mfl;
        in_valid_s[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_s[i] = 1'b0;
        // Scramble inputs after accept: the running compare must ignore them.
        is_signed_s[i] = ~sgn; a_s[i] = ~a; b_s[i] = a;
        k = 0;
        while (!out_valid_s[i] && k < 64) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check({nm, " latency"}, k, mk);
        repeat (hold) begin
            check({nm, " hold out_valid"}, out_valid_s[i], 1'b1);
            check({nm, " hold in_ready"}, in_ready_s[i], 1'b0);
            @(negedge clk);
        end
        out_ready_s[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_s[i] = 1'b0;
        check({nm, " idle after hs"}, {out_valid_s[i], in_ready_s[i], busy_s[i]}, 3'b010);
        check({nm, " flags held"}, {bigger_s[i], equal_s[i], less_s[i]}, mfl);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            a_s[i] = '0; b_s[i] = '0; exp_flags[i] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", in_ready_s, 4'hF);
        check("reset out_valid", out_valid_s, 4'h0);
        check("reset busy", busy_s, 4'h0);
        check("reset flags", {bigger_s, equal_s, less_s}, 12'h000);
        rst_n = 1'b1;

        run_op(0, 64'h12345678, 64'h12345679, 1'b0, 3'b001, 4, 0, "lsb diff");
        run_op(0, 64'h80000000, 64'h00000001, 1'b1, 3'b001, 1, 0, "msb signed");
        run_op(0, 64'h80000000, 64'h00000001, 1'b0, 3'b100, 1, 0, "msb unsigned");
        run_op(0, 64'hDEADBEEF, 64'hDEADBEEF, 1'b1, 3'b010, 4, 0, "eq deadbeef");
        run_op(0, 64'h0, 64'h0, 1'b0, 3'b010, 4, 0, "eq zero");
        run_op(0, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 3'b010, 4, 0, "eq ones");
        run_op(0, 64'h00FF0000, 64'h00FE0000, 1'b0, 3'b100, 2, 3, "backpressure");

        // Reset in the second RUN cycle: outputs clear at once, no result.
        @(negedge clk);
        a_s[0] = 64'h55; b_s[0] = 64'h55; is_signed_s[0] = 1'b0;
        in_valid_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre-reset busy", busy_s[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrun reset outs", {out_valid_s[0], busy_s[0], in_ready_s[0]}, 3'b001);
        check("midrun reset flags", {bigger_s[0], equal_s[0], less_s[0]}, 3'b000);
        repeat (3) begin
            @(negedge clk);
            check("reset no out_valid", out_valid_s[0], 1'b0);
        end
        rst_n = 1'b1;
        run_op(0, 64'h00000010, 64'h00000020, 1'b1, 3'b001, 4, 0, "post reset");

        run_op(1, 64'hFF000000, 64'h00FFFFFF, 1'b0, 3'b100, 4, 0, "fixed first diff");
        run_op(1, 64'hFF000000, 64'h00FFFFFF, 1'b1, 3'b001, 4, 1, "fixed signed");
        run_op(2, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b1, 3'b001, 1, 0, "w64 signed");
        run_op(2, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b0, 3'b100, 1, 0, "w64 unsigned");
        run_op(3, 64'h5, 64'h7, 1'b0, 3'b001, 1, 0, "full width");
        run_op(3, 64'h80000000, 64'h7FFFFFFF, 1'b1, 3'b001, 1, 0, "full signed");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
